// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multi-cycle RV32I core: sequences ALU, memory port, IR, PC and RF writes.
// Moore decode of state (plus mem_ready/zero); memory waits are bounded by a timeout into a sticky FAULT.
module multicycle_main_fsm #(
    parameter int unsigned WAIT_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        FAULT    = 4'd11
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(WAIT_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] fault_code_q, fault_code_d;
    logic       wait_st;
    logic       branch;
    logic       pc_update;
    logic       timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            wait_cnt_q   <= '0;
            fault_code_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            fault_code_q <= fault_code_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        wait_st      = 1'b0;
        branch       = 1'b0;
        pc_update    = 1'b0;
        mem_req      = 1'b0;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
        RegWrite     = 1'b0;

        case (state_q)
            FETCH: begin
                wait_st   = 1'b1;
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                pc_update = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011,
                    7'b0100011: state_d = MEMADR;
                    7'b0110011: state_d = EXECR;
                    7'b0010011: state_d = EXECI;
                    7'b1100011: state_d = BEQ;
                    7'b1101111: state_d = JAL;
                    default: begin
                        state_d      = FAULT;
                        fault_code_d = 2'b01;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                wait_st = 1'b1;
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                wait_st  = 1'b1;
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
                state_d = FETCH;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            FAULT: state_d = FAULT;
            default: state_d = FETCH;
        endcase

        // A completing access on the last tolerated cycle takes priority over the timeout.
        timeout = wait_st && !mem_ready && (wait_cnt_q == CNT_LAST);
        if (timeout) begin
            state_d      = FAULT;
            fault_code_d = 2'b10;
        end

        wait_cnt_d = (wait_st && !mem_ready && !timeout) ? wait_cnt_q + 8'd1 : 8'd0;
        PCWrite    = (branch & zero) | pc_update;
    end

    assign fault      = (state_q == FAULT);
    assign fault_code = fault_code_q;
    assign state_dbg  = state_q;

endmodule
